// File: rtl/dvs_ravens_pkt_sched.sv
// Spike/host packet scheduler for the RAVENS sink with periodic RUN insertion at timestep boundaries.
// Optional drop counter output enabled by defining DVS_SCHED_DROP_CNT_EN.
module dvs_ravens_pkt_sched #(
   parameter int PKT_BITS    = 32,
   parameter int FIFO_DEPTH  = 16,
   parameter int TICK_CYCLES = 1200
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run_en,
   input  logic [PKT_BITS-1:0] evt_pkt,
   input  logic                evt_valid,
   input  logic [PKT_BITS-1:0] host_pkt,
   input  logic                host_valid,
   output logic                host_ready,
   output logic [PKT_BITS-1:0] out_pkt,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                fifo_full,
   output logic                tick_overrun
`ifdef DVS_SCHED_DROP_CNT_EN
   ,
   output logic [15:0]         drop_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TICK_LAST_C = TW'(TICK_CYCLES - 1);
   localparam logic [PKT_BITS-1:0] RAVENS_RUN = {3'b001, {(PKT_BITS-4){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_HOLD_HOST = 2'd1,
      ST_HOLD_EVT  = 2'd2,
      ST_HOLD_RUN  = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [PKT_BITS-1:0] out_pkt_r;
   logic                out_valid_r;
   logic [PKT_BITS-1:0] load_pkt_s;
   logic                load_valid_s;

   logic [PKT_BITS-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_r;
   logic [AW-1:0]       rd_ptr_r;
   logic [CW-1:0]       count_r;
   logic [CW-1:0]       count_next_s;
   logic                fifo_full_r;
   logic                full_s;
   logic                fifo_empty_s;
   logic [PKT_BITS-1:0] fifo_head_s;

   logic [TW-1:0]       tick_cnt_r;
   logic                tick_pending_r;
   logic [CW-1:0]       pre_tick_cnt_r;
   logic                tick_overrun_r;
   logic                tick_wrap_s;

   logic                slot_free_s;
   logic                push_s;
   logic                pop_s;
   logic                pop_pre_s;
   logic                load_run_s;

   assign slot_free_s  = ~out_valid_r | out_ready;
   assign host_ready   = slot_free_s;
   assign full_s       = (count_r == DEPTH_C);
   assign fifo_empty_s = (count_r == {CW{1'b0}});
   assign fifo_head_s  = mem_r[rd_ptr_r];
   assign push_s       = evt_valid & (~full_s | pop_s);
   assign count_next_s = count_r + CW'(push_s) - CW'(pop_s);
   assign tick_wrap_s  = run_en & (tick_cnt_r == TICK_LAST_C);

   assign out_pkt      = out_pkt_r;
   assign out_valid    = out_valid_r;
   assign fifo_full    = fifo_full_r;
   assign tick_overrun = tick_overrun_r;

   // Candidate selection: host, pre-tick spike, RUN, post-tick spike, in that order.
   always_comb begin
      state_s      = state_r;
      load_pkt_s   = out_pkt_r;
      load_valid_s = out_valid_r;
      pop_s        = 1'b0;
      pop_pre_s    = 1'b0;
      load_run_s   = 1'b0;
      if (slot_free_s) begin
         if (host_valid) begin
            state_s      = ST_HOLD_HOST;
            load_pkt_s   = host_pkt;
            load_valid_s = 1'b1;
         end else if ((pre_tick_cnt_r != {CW{1'b0}}) && !fifo_empty_s) begin
            state_s      = ST_HOLD_EVT;
            load_pkt_s   = fifo_head_s;
            load_valid_s = 1'b1;
            pop_s        = 1'b1;
            pop_pre_s    = 1'b1;
         end else if (tick_pending_r) begin
            state_s      = ST_HOLD_RUN;
            load_pkt_s   = RAVENS_RUN;
            load_valid_s = 1'b1;
            load_run_s   = 1'b1;
         end else if (!fifo_empty_s) begin
            state_s      = ST_HOLD_EVT;
            load_pkt_s   = fifo_head_s;
            load_valid_s = 1'b1;
            pop_s        = 1'b1;
         end else begin
            state_s      = ST_IDLE;
            load_valid_s = 1'b0;
         end
      end else begin
         state_s = state_r;
      end
   end

   // Output register and FSM state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         out_pkt_r   <= {PKT_BITS{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         out_pkt_r   <= load_pkt_s;
         out_valid_r <= load_valid_s;
      end
   end

   // Spike storage; contents are don't-care once the pointers are reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= evt_pkt;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         count_r     <= {CW{1'b0}};
         fifo_full_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r     <= count_next_s;
         fifo_full_r <= (count_next_s == DEPTH_C);
      end
   end

   // Timestep counter; spikes queued at a boundary must leave before the RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt_r     <= {TW{1'b0}};
         tick_pending_r <= 1'b0;
         pre_tick_cnt_r <= {CW{1'b0}};
         tick_overrun_r <= 1'b0;
      end else begin
         if (!run_en || tick_wrap_s) begin
            tick_cnt_r <= {TW{1'b0}};
         end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
         end
         if (tick_wrap_s) begin
            tick_pending_r <= 1'b1;
            pre_tick_cnt_r <= count_next_s;
            if (tick_pending_r) begin
               tick_overrun_r <= 1'b1;
            end
         end else begin
            if (load_run_s) begin
               tick_pending_r <= 1'b0;
            end
            if (pop_pre_s) begin
               pre_tick_cnt_r <= pre_tick_cnt_r - CW'(1);
            end
         end
      end
   end

`ifdef DVS_SCHED_DROP_CNT_EN
   logic        drop_s;
   logic [15:0] drop_cnt_r;

   assign drop_s   = evt_valid & ~push_s;
   assign drop_cnt = drop_cnt_r;

   // Saturating count of spikes lost to a full FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt_r <= 16'h0000;
      end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
         drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
   end
`endif

endmodule
